fetch_scheduler: RTL and testbench

Read scheduler for the `fetcher` block. It watches the fetcher's per-lane `empty` flags, issues single-cycle `read` pops to one lane at a time in round-robin order, and forwards each popped word to one downstream valid/ready stream tagged with its lane index. It sits between the `fetcher` (12 lanes × 8 bit) and the single-issue compute datapath.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_scheduler_rr_pick.sv | 31 +++
 rtl/fetch_scheduler.sv | 130 +++++++++++++
 tb/tb_fetch_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared sizes and scheduler state type for the fetch read scheduler
package fetch_pkg;

    localparam int LANES = 12;
    localparam int WIDTH = 8;
    localparam int IDXW  = $clog2(LANES);
    localparam int BURST = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        STALL  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fetch_scheduler_rr_pick.sv
// rtl/fetch_scheduler_rr_pick.sv - rotate-priority encoder: first set req at or after ptr
module rr_pick
    import fetch_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [IDXW-1:0]  gnt_idx,
    output logic             gnt_valid
);

    int              idx;
    logic [IDXW-1:0] sel;

    // Walk from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= LANES) idx = idx - LANES;
            sel = IDXW'(idx);
            if (req[sel]) begin
                gnt_idx   = sel;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_scheduler.sv
// rtl/fetch_scheduler.sv - round-robin pop scheduler from fetcher lanes to one valid/ready stream
// Optional FETCH_SCHED_BURST_EN: keep the grant on one lane for up to BURST consecutive pops.
module fetch_scheduler
    import fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES-1:0]       empty,
    input  logic [LANES*WIDTH-1:0] fetch_data,
    output logic [LANES-1:0]       read,
    output logic [WIDTH-1:0]       m_data,
    output logic [IDXW-1:0]        m_lane,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy
);

    sched_state_t    state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [IDXW-1:0] m_lane_q, m_lane_d;

    logic [LANES-1:0] elig;
    logic             space;
    logic [IDXW-1:0]  rr_idx, gnt_idx;
    logic             rr_valid, gnt_valid;
    logic             pop;

    assign elig  = lane_en & ~empty;
    assign space = ~m_valid_q | m_ready;

    rr_pick u_pick (
        .req       (elig),
        .ptr       (ptr_q),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

`ifdef FETCH_SCHED_BURST_EN
    localparam int CNTW = $clog2(BURST + 1);

    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IDXW-1:0] burst_lane_q, burst_lane_d;
    logic            hold;

    // ptr already points past the burst lane, so a broken burst resumes the rotation.
    assign hold      = (burst_cnt_q != '0) & elig[burst_lane_q];
    assign gnt_idx   = hold ? burst_lane_q : rr_idx;
    assign gnt_valid = hold | rr_valid;
`else
    assign gnt_idx   = rr_idx;
    assign gnt_valid = rr_valid;
`endif

    assign pop  = space & gnt_valid & ~rst;
    assign read = pop ? (LANES'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d     = ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_lane_d  = m_lane_q;
        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fetch_data[gnt_idx*WIDTH +: WIDTH];
            m_lane_d  = gnt_idx;
            ptr_d     = (gnt_idx == IDXW'(LANES - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

`ifdef FETCH_SCHED_BURST_EN
    always_comb begin
        burst_cnt_d  = burst_cnt_q;
        burst_lane_d = burst_lane_q;
        if (pop) begin
            if (hold) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d  = CNTW'(1);
                burst_lane_d = gnt_idx;
            end
            if (burst_cnt_d == CNTW'(BURST)) burst_cnt_d = '0;
        end else if (!hold) begin
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q  <= '0;
            burst_lane_q <= '0;
        end else begin
            burst_cnt_q  <= burst_cnt_d;
            burst_lane_q <= burst_lane_d;
        end
    end
`endif

    always_comb begin
        state_d = IDLE;
        if (m_valid_d & ~m_ready) state_d = STALL;
        else if (pop)             state_d = STREAM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_lane_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_lane_q  <= m_lane_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_lane  = m_lane_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_scheduler.sv
// tb/tb_fetch_scheduler.sv - randomized bench for fetch_scheduler against a behavioural model
module tb_fetch_scheduler;
    import fetch_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [LANES-1:0]       lane_en;
    logic [LANES-1:0]       empty;
    logic [LANES*WIDTH-1:0] fetch_data;
    logic [LANES-1:0]       read;
    logic [WIDTH-1:0]       m_data;
    logic [IDXW-1:0]        m_lane;
    logic                   m_valid;
    logic                   m_ready;
    logic                   busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state
    int         mdl_ptr   = 0;
    int         mdl_bcnt  = 0;
    int         mdl_blane = 0;
    bit         mdl_valid = 0;
    logic [7:0] mdl_data  = 0;
    int         mdl_lane  = 0;
    bit         mdl_busy  = 0;

    fetch_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .lane_en    (lane_en),
        .empty      (empty),
        .fetch_data (fetch_data),
        .read       (read),
        .m_data     (m_data),
        .m_lane     (m_lane),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < LANES; i++) fetch_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    // One clock: predict from current inputs, compare, then advance the model on the edge.
    task automatic step();
        bit               found;
        int               g;
        bit               pop;
        bit [LANES-1:0]   elig;
        bit [LANES-1:0]   exp_read;
        bit               space;
        elig  = lane_en & ~empty;
        space = !mdl_valid || m_ready;
        found = 0;
        g     = 0;
`ifdef FETCH_SCHED_BURST_EN
        if (mdl_bcnt > 0 && elig[mdl_blane]) begin
            found = 1;
            g     = mdl_blane;
        end
`endif
        for (int k = 0; k < LANES && !found; k++) begin
            if (elig[(mdl_ptr + k) % LANES]) begin
                found = 1;
                g     = (mdl_ptr + k) % LANES;
            end
        end
        pop      = space && found && !rst;
        exp_read = '0;
        if (pop) exp_read[g] = 1'b1;

        #2;
        check("read", 32'(read), 32'(exp_read));
        check("m_valid", 32'(m_valid), 32'(mdl_valid));
        check("m_data", 32'(m_data), 32'(mdl_data));
        check("m_lane", 32'(m_lane), 32'(mdl_lane));
        check("busy", 32'(busy), 32'(mdl_busy));

        @(posedge clk);
        if (rst) begin
            mdl_ptr = 0; mdl_bcnt = 0; mdl_blane = 0;
            mdl_valid = 0; mdl_data = 0; mdl_lane = 0; mdl_busy = 0;
        end else begin
            if (pop) begin
                mdl_data  = fetch_data[g*WIDTH +: WIDTH];
                mdl_lane  = g;
                mdl_valid = 1;
                mdl_ptr   = (g + 1) % LANES;
`ifdef FETCH_SCHED_BURST_EN
                if (mdl_bcnt > 0 && g == mdl_blane) mdl_bcnt++;
                else begin
                    mdl_bcnt  = 1;
                    mdl_blane = g;
                end
                if (mdl_bcnt == BURST) mdl_bcnt = 0;
`endif
            end else begin
                if (m_ready) mdl_valid = 0;
`ifdef FETCH_SCHED_BURST_EN
                if (mdl_bcnt > 0 && !elig[mdl_blane]) mdl_bcnt = 0;
`endif
            end
            mdl_busy = (mdl_valid && !m_ready) || pop;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        lane_en = '1;
        empty   = '0;
        m_ready = 1'b1;
        randomize_data();
        @(posedge clk);
        #1;

        // Reset held with all lanes full
        run(3);
        rst = 1'b0;
        run(2);

        // Fairness over lanes 0, 1, 5
        empty = ~12'b0000_0010_0011;
        run(8);

        // Backpressure with lane 3 holding A5
        empty = ~12'b0000_0000_1000;
        fetch_data[3*WIDTH +: WIDTH] = 8'hA5;
        run(1);
        m_ready = 1'b0;
        run(4);
        m_ready = 1'b1;
        run(3);

        // Mask and wrap
        empty   = '0;
        lane_en = 12'h801;
        run(6);
        lane_en = 12'h001;
        run(4);

        // Lanes 2 and 7, then lane 2 runs dry
        lane_en = '1;
        empty   = ~12'b0000_1000_0100;
        run(9);
        empty   = ~12'b0000_1000_0000;
        run(3);

        // Reset while a word is held
        empty   = '0;
        m_ready = 1'b0;
        run(1);
        rst = 1'b1;
        run(1);
        rst     = 1'b0;
        m_ready = 1'b1;
        run(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom % 64) == 0;
            lane_en = ($urandom % 4 == 0) ? LANES'($urandom) : '1;
            empty   = ($urandom % 2 == 0) ? LANES'($urandom) : LANES'($urandom | $urandom);
            m_ready = ($urandom % 4) != 0;
            randomize_data();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
